// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//
// Shares a bank of DEPTH level-sensitive D latches among NREQ requesters.
// One write request is granted per transaction. The winner's address and
// data are captured at the grant edge. The latch write then runs through
// SETUP (data settles, enables closed), ENABLE (one enable open for EN_CYCLES
// cycles) and HOLD (enables closed, data still held). Every output comes
// straight from a flop, so the enables are glitch-free. lat_d only changes at
// a grant edge, which is always in IDLE with every enable closed.
//
// Arbitration: round-robin by default. The search starts one past the
// previous winner. Defining LATCH_ARB_FIXED_PRIO_EN switches to fixed
// priority, where the lowest active index wins. Timing is the same in both
// modes.
//
// Handshake: req[i] is a level and is sampled only in IDLE. gnt[i] is high
// from the grant edge through the end of HOLD. done[i] pulses for the one
// IDLE cycle after HOLD. A requester may drop req at any time after gnt
// without aborting the write. It may keep req high to compete again in its
// done cycle.
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   rst      asynchronous, active-high reset; clears every output at once
//   req      per-requester write request (level)
//   wr_addr  per-requester latch index; requester i at [i*AW +: AW]
//   wr_data  per-requester data; requester i at [i*WIDTH +: WIDTH]
//   gnt      one-hot owner, SETUP through HOLD
//   done     one-cycle pulse to the owner after HOLD
//   busy     high whenever the FSM is not in IDLE
//   lat_d    shared latch D bus
//   lat_en   one-hot latch enables; all zero for an out-of-range address
module latch_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int EN_CYCLES = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      lat_d,
    output logic [DEPTH-1:0]      lat_en
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   cap_addr;
    logic [CW-1:0]   cnt;
    logic            any_req;
    logic [IW-1:0]   pick;

    // An index at or above DEPTH decodes to no enable at all. This can only
    // happen when DEPTH is not a power of two.
    function automatic logic [DEPTH-1:0] addr_decode(input logic [AW-1:0] a);
        logic [DEPTH-1:0] oh;
        oh = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (int'(a) == j) oh[j] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] w);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (int'(w) == j) oh[j] = 1'b1;
        end
        return oh;
    endfunction

`ifdef LATCH_ARB_FIXED_PRIO_EN
    // Fixed priority. The loop scans downward so the lowest active index
    // is the last one written and therefore wins.
    always_comb begin
        any_req = |req;
        pick    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) pick = IW'(k);
        end
    end
`else
    logic [IW-1:0] last_winner;
    logic          found;
    int            idx;

    // Round-robin. Scan NREQ slots starting one past the previous winner,
    // wrapping modulo NREQ. The first active request found wins.
    always_comb begin
        any_req = |req;
        pick    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last_winner) + 1 + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Resets to NREQ-1 so that requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= IW'(NREQ - 1);
        end else if (state == IDLE && any_req) begin
            last_winner <= pick;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            lat_d    <= '0;
            lat_en   <= '0;
            cap_addr <= '0;
            cnt      <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // Sample the request only here. Later changes to
                        // req, wr_addr or wr_data have no effect on this write.
                        gnt      <= to_onehot(pick);
                        cap_addr <= wr_addr[int'(pick)*AW +: AW];
                        lat_d    <= wr_data[int'(pick)*WIDTH +: WIDTH];
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    lat_en <= addr_decode(cap_addr);
                    cnt    <= '0;
                    state  <= ENABLE;
                end
                ENABLE: begin
                    if (cnt == CW'(EN_CYCLES - 1)) begin
                        lat_en <= '0;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    // gnt still holds the owner, so it becomes the done pulse.
                    done  <= gnt;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
module tb_latch_bank_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int EN_CYCLES = 2;
  localparam int AW = 2;
  localparam logic [7:0] EXP_SHAPE = 8'(((1 << EN_CYCLES) - 1) << 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (DEPTH=4)
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] wr_addr = '0;
  logic [NREQ*WIDTH-1:0] wr_data = '0;
  logic [NREQ-1:0] gnt, done;
  logic busy;
  logic [WIDTH-1:0] lat_d;
  logic [DEPTH-1:0] lat_en;

  latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .EN_CYCLES(EN_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .done(done), .busy(busy), .lat_d(lat_d), .lat_en(lat_en)
  );

  // second instance with a non-power-of-two bank (DEPTH=3)
  logic [NREQ-1:0] req_b = '0;
  logic [NREQ*2-1:0] wr_addr_b = '0;
  logic [NREQ*WIDTH-1:0] wr_data_b = '0;
  logic [NREQ-1:0] gnt_b, done_b;
  logic busy_b;
  logic [WIDTH-1:0] lat_d_b;
  logic [2:0] lat_en_b;

  latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(3), .EN_CYCLES(EN_CYCLES)) dut_odd (
    .clk(clk), .rst(rst), .req(req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .lat_d(lat_d_b), .lat_en(lat_en_b)
  );

  // ---------------- scoreboard ----------------
  // entry = {done vector, lat_en vector, data}
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [NREQ-1:0] prev_gnt = '0;
  logic [NREQ-1:0] gnt_seen = '0;
  logic [DEPTH-1:0] en_or = '0;
  logic [7:0] shape = '0;
  logic [WIDTH-1:0] first_d = '0;
  logic d_moved = 1'b0;
  int gnt_len = 0;
  int done_cyc[NREQ];
  int gnt_rise_cyc[NREQ];

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      prev_gnt = '0;
      gnt_len = 0;
    end else begin
      if (gnt != '0) begin
        if (prev_gnt == '0) begin
          first_d = lat_d;
          gnt_seen = '0;
          en_or = '0;
          shape = '0;
          d_moved = 1'b0;
          gnt_len = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_rise_cyc[i] = cyc;
        end
        gnt_seen = gnt_seen | gnt;
        en_or = en_or | lat_en;
        shape = {shape[6:0], |lat_en};
        if (lat_d !== first_d) d_moved = 1'b1;
        gnt_len++;
      end
      if (done != '0) begin
        for (int i = 0; i < NREQ; i++) if (done[i]) done_cyc[i] = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_vec", 32'(done), 32'(e[15:12]));
          check("gnt_owner", 32'(gnt_seen), 32'(e[15:12]));
          check("lat_d_setup", 32'(first_d), 32'(e[7:0]));
          check("lat_d_stable", 32'(d_moved), 32'd0);
          check("lat_en_sel", 32'(en_or), 32'(e[11:8]));
          check("en_shape", 32'(shape), 32'(EXP_SHAPE));
          check("gnt_len", 32'(gnt_len), 32'(EN_CYCLES + 2));
          check("gnt_in_done", 32'(gnt), 32'd0);
          check("busy_in_done", 32'(busy), 32'd0);
          check("lat_d_hold", 32'(lat_d), 32'(e[7:0]));
        end
      end
      prev_gnt = gnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
  endtask

  task automatic push_exp(input int w, input logic [1:0] addr, input logic [7:0] data);
    logic [3:0] dv;
    logic [3:0] ev;
    dv = 4'b0001 << w;
    ev = 4'b0001 << addr;
    exp_q.push_back({dv, ev, data});
  endtask

  // ---------------- stimulus ----------------
  int rr_order[5];
  int t_req;

  initial begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
    rr_order = '{0, 0, 0, 0, 0};
`else
    rr_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NREQ; i++) begin
      done_cyc[i] = -1;
      gnt_rise_cyc[i] = -1;
    end

    // reset values
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lat_d", 32'(lat_d), 32'd0);
    check("rst_lat_en", 32'(lat_en), 32'd0);

    // single write from requester 2
    wr_addr[2*AW +: AW] = 2'd3;
    wr_data[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    push_exp(2, 2'd3, 8'hA5);
    wait_cycles(1);
    req = '0;
    wait_cycles(8);

    // round-robin fairness from a fresh reset
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      wr_addr[i*AW +: AW] = 2'(i);
      wr_data[i*WIDTH +: WIDTH] = 8'hC0 + 8'(i);
    end
    for (int k = 0; k < 5; k++) push_exp(rr_order[k], 2'(rr_order[k]), 8'hC0 + 8'(rr_order[k]));
    req = 4'b1111;
    wait_cycles(21);
    req = '0;
    wait_cycles(8);

    // data stability: wr_data changes after the grant
    wr_addr[0 +: AW] = 2'd1;
    wr_data[0 +: WIDTH] = 8'h11;
    req = 4'b0001;
    push_exp(0, 2'd1, 8'h11);
    wait_cycles(1);
    req = '0;
    wait_cycles(1);
    wr_data[0 +: WIDTH] = 8'h22;
    wait_cycles(7);

    // reset in the second ENABLE cycle
    req = 4'b0001;
    wait_cycles(1);
    req = '0;
    wait_cycles(2);
    check("pre_rst_lat_en", 32'(lat_en), 32'h2);
    rst = 1'b1;
    #1;
    check("async_lat_en", 32'(lat_en), 32'd0);
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_lat_d", 32'(lat_d), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wr_addr[1*AW +: AW] = 2'd2;
    wr_data[1*WIDTH +: WIDTH] = 8'h3C;
    req = 4'b0110;
    push_exp(1, 2'd2, 8'h3C);
    wait_cycles(1);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_cycles(8);

    // back-to-back: requesters 0 and 1
    wr_addr[0 +: AW] = 2'd1;
    wr_data[0 +: WIDTH] = 8'h77;
    wr_addr[1*AW +: AW] = 2'd2;
    wr_data[1*WIDTH +: WIDTH] = 8'h88;
    push_exp(0, 2'd1, 8'h77);
    push_exp(1, 2'd2, 8'h88);
    t_req = cyc;
    req = 4'b0011;
    wait_cycles(1);
    req = 4'b0010;
    wait_cycles(5);
    req = '0;
    wait_cycles(8);
    check("b2b_done0_time", 32'(done_cyc[0] - t_req), 32'(EN_CYCLES + 3));
    check("b2b_gnt1_time", 32'(gnt_rise_cyc[1] - t_req), 32'(EN_CYCLES + 4));
    check("b2b_total_time", 32'(done_cyc[1] - t_req), 32'(2 * (EN_CYCLES + 3)));

    // out-of-range address on the DEPTH=3 instance
    begin
      logic en_bad;
      int dcyc;
      logic [NREQ-1:0] dval;
      en_bad = 1'b0;
      dcyc = -1;
      dval = '0;
      wr_addr_b[0 +: 2] = 2'd3;
      wr_data_b[0 +: WIDTH] = 8'h5A;
      t_req = cyc;
      req_b = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
        wait_cycles(1);
        if (k == 1) req_b = '0;
        if (lat_en_b != 3'd0) en_bad = 1'b1;
        if (done_b != '0 && dcyc < 0) begin
          dcyc = cyc;
          dval = done_b;
        end
      end
      check("oor_lat_en", 32'(en_bad), 32'd0);
      check("oor_done_time", 32'(dcyc - t_req), 32'(EN_CYCLES + 3));
      check("oor_done_vec", 32'(dval), 32'h1);
      check("oor_lat_d", 32'(lat_d_b), 32'h5A);
      check("oor_busy", 32'(busy_b), 32'd0);
    end

    // drain the scoreboard with a bound
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) wait_cycles(1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/latch_bank_arbiter.md
# latch_bank_arbiter

- Shares a bank of DEPTH level-sensitive D latches among NREQ requesters.
- Picks one write request per transaction by round-robin arbitration, captures its address and data, and sequences the latch write through setup, enable and hold phases.
- Drives glitch-free registered enables so latch data never changes while an enable is open.
- Sits between requester logic and the latch storage array; it is the only driver of the latch D and EN inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, latch data width
- DEPTH, 4, number of latches in bank; AW = $clog2(DEPTH) (min 1)
- EN_CYCLES, 2, cycles lat_en stays open (>=1)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request, level
- wr_addr  input  NREQ*AW  per-requester latch index, requester i at [i*AW +: AW]
- wr_data  input  NREQ*WIDTH  per-requester data, requester i at [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot; high for the owning requester from SETUP through HOLD
- done  output  NREQ  one-cycle pulse to the owner after HOLD
- busy  output  1  high when state != IDLE
- lat_d  output  WIDTH  shared D bus to all latches
- lat_en  output  DEPTH  one-hot latch enables

## Operation
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE: if any req bit is high at a clock edge, the arbiter selects a winner w.
  - Captures wr_addr[w] and wr_data[w] into internal registers.
  - Sets gnt[w] and moves to SETUP.
  - If no req bit is high, stays in IDLE.
- SETUP: lasts 1 cycle. lat_d = captured data; lat_en all 0.
- ENABLE: lasts EN_CYCLES cycles.
  - lat_en[captured addr] = 1, all other bits 0.
  - A cycle counter runs from 0 to EN_CYCLES-1.
- HOLD: lasts 1 cycle. lat_en all 0; lat_d unchanged.
- HOLD -> IDLE: clears gnt and pulses done[w] during the first IDLE cycle.
- Round-robin rule:
  - The search starts at index last_winner+1 and wraps modulo NREQ.
  - last_winner is updated on every grant.
  - last_winner resets to NREQ-1, so req[0] has first priority.
- Request capture:
  - Request data is sampled only at the grant edge. Later changes to req, wr_addr or wr_data do not affect the transaction in flight.
  - Dropping req after grant does not abort the transaction.
- Requests arriving while busy wait; they are not queued beyond their level.
- A requester still holding req in its done cycle is eligible again, subject to round-robin order.
- Out-of-range address (DEPTH not a power of two, addr >= DEPTH):
  - No lat_en bit asserts.
  - The sequence still runs in full and done pulses.
- lat_d holds its last value in IDLE and is never changed while any lat_en bit is high.

## Timing
- All outputs are registered.
- Reset values: gnt=0, done=0, busy=0, lat_d=0, lat_en=0, state=IDLE.
- Grant edge T:
  - SETUP occupies cycle T..T+1.
  - lat_en is high during cycles T+1 .. T+1+EN_CYCLES.
  - HOLD ends at edge T+2+EN_CYCLES.
  - done is high for the following cycle.
- Occupancy is EN_CYCLES+3 cycles per transaction.
- The next grant may occur at the edge ending the done cycle, so done and a new gnt are never high in the same cycle.
- Reset asserted mid-transaction:
  - All outputs clear immediately (asynchronously), without waiting for a clock edge.
  - No done is issued.
  - The latch retains whatever it had captured by then.
- Deassertion of rst takes effect at the next rising edge; the FSM starts in IDLE.

## Configuration
- LATCH_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index active req always wins and last_winner is unused.
- LATCH_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- Timing and FSM are identical in both modes.

## Test plan
- Reset then single write: req[2]=1, wr_addr[2]=3, wr_data[2]=8'hA5.
  - Expect gnt=4'b0100 for 1+EN_CYCLES+1 cycles.
  - Expect lat_d=8'hA5 from SETUP onward.
  - Expect lat_en=4'b1000 for exactly 2 cycles, bracketed by 1 zero cycle on each side.
  - Expect done[2] pulse, then busy=0.
- Round-robin fairness: req=4'b1111 held constant.
  - Expect grant order 0,1,2,3,0.
  - Under LATCH_ARB_FIXED_PRIO_EN, expect 0,0,0.
- Data stability: change wr_data[0] from 8'h11 to 8'h22 one cycle after gnt[0].
  - Expect lat_d to stay 8'h11 through HOLD.
- Reset mid-ENABLE: assert rst in the second ENABLE cycle.
  - Expect lat_en, gnt and busy to go 0 without waiting for a clock edge.
  - Expect no done pulse.
  - After release, req[1] is granted first.
- Back-to-back: req[0] and req[1] both high.
  - Expect done[0] and gnt[1] to rise in consecutive cycles, never overlapping.
  - Expect total time for two writes = 2*(EN_CYCLES+3) cycles.
- Out-of-range address: DEPTH=3, addr=3.
  - Expect lat_en to stay 0 throughout.
  - Expect done pulse after EN_CYCLES+3 cycles.
